// File: rtl/pattern_sequencer.sv
// Random pattern generator/replayer: Galois LFSR draws SYM_W-bit symbols into a buffer, replayed over valid/ready.
// Optional build macro NO_REPEAT_EN: bumps a draw that would repeat the previous symbol.
module pattern_sequencer #(
  parameter int                SYM_W     = 3,
  parameter int                MAX_LEN   = 16,
  parameter int                LEN_W     = 5,
  parameter int                LFSR_W    = 20,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 20'h90000
) (
  input  logic              clk_1,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              gen_start,
  input  logic [LEN_W-1:0]  gen_len,
  output logic              gen_busy,
  output logic              gen_done,
  output logic [LEN_W-1:0]  pat_len,
  input  logic              play_start,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic [SYM_W-1:0]  sym_out,
  output logic              sym_last
);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {IDLE, GEN, DONE, PLAY} state_t;
  state_t state, state_nx;

  logic [LFSR_W-1:0]             lfsr;
  logic [MAX_LEN-1:0][SYM_W-1:0] pat_mem;
  logic [LEN_W-1:0]              len_q, idx, len_clamp;
  logic [SYM_W-1:0]              raw, sym_wr;
  logic                          start_gen, wr_en, gen_fin, start_play, xfer, play_fin;

  // Free-running so player timing decides where in the sequence a pattern is drawn
  always_ff @(posedge clk_1 or negedge rst)
    if (!rst)           lfsr <= LFSR_W'(1);
    else if (seed_load) lfsr <= (seed == '0) ? LFSR_W'(1) : seed;
    else                lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);

  assign raw = lfsr[SYM_W-1:0] ^ lfsr[SYM_W+3:4];

`ifdef NO_REPEAT_EN
  logic [SYM_W-1:0] prev_sym;
  always_ff @(posedge clk_1 or negedge rst)
    if (!rst)       prev_sym <= '0;
    else if (wr_en) prev_sym <= sym_wr;
  assign sym_wr = (idx != '0 && raw == prev_sym) ? raw + SYM_W'(1) : raw;
`else
  assign sym_wr = raw;
`endif

  always_comb begin
    len_clamp = gen_len;
    if (gen_len == '0)                   len_clamp = LEN_W'(1);
    else if (gen_len > LEN_W'(MAX_LEN))  len_clamp = LEN_W'(MAX_LEN);
  end

  always_ff @(posedge clk_1 or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (gen_start) state_nx = GEN;
      GEN:  if (idx == len_q - LEN_W'(1)) state_nx = DONE;
      DONE: if (play_start)     state_nx = PLAY;
            else if (gen_start) state_nx = GEN;
      PLAY: if (sym_valid && sym_ready && sym_last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // play_start has priority over gen_start in DONE
  always_comb begin
    start_gen  = (state == IDLE && gen_start) || (state == DONE && gen_start && !play_start);
    wr_en      = (state == GEN);
    gen_fin    = wr_en && (idx == len_q - LEN_W'(1));
    start_play = (state == DONE) && play_start;
    xfer       = (state == PLAY) && sym_valid && sym_ready;
    play_fin   = xfer && sym_last;
  end

  always_ff @(posedge clk_1 or negedge rst)
    if (!rst) begin
      gen_busy  <= 1'b0;
      gen_done  <= 1'b0;
      pat_len   <= '0;
      sym_valid <= 1'b0;
      sym_out   <= '0;
      sym_last  <= 1'b0;
      idx       <= '0;
      len_q     <= '0;
    end else if (start_gen) begin
      len_q    <= len_clamp;
      idx      <= '0;
      gen_busy <= 1'b1;
      gen_done <= 1'b0;
    end else if (wr_en) begin
      idx <= idx + LEN_W'(1);
      if (gen_fin) begin
        gen_busy <= 1'b0;
        gen_done <= 1'b1;
        pat_len  <= len_q;
      end
    end else if (start_play) begin
      sym_valid <= 1'b1;
      sym_out   <= pat_mem[0];
      sym_last  <= (pat_len == LEN_W'(1));
      idx       <= LEN_W'(1);
    end else if (xfer) begin
      if (play_fin) begin
        // sym_out deliberately held after the final transfer
        sym_valid <= 1'b0;
        sym_last  <= 1'b0;
      end else begin
        sym_out  <= pat_mem[idx[IDX_W-1:0]];
        sym_last <= (idx == pat_len - LEN_W'(1));
        idx      <= idx + LEN_W'(1);
      end
    end

  // Buffer has no reset; contents only meaningful once gen_done is set
  always_ff @(posedge clk_1)
    if (wr_en) pat_mem[idx[IDX_W-1:0]] <= sym_wr;

endmodule
